// File: rtl/flexcounter_scheduler.sv
// flexcounter_scheduler: shares one flexcounter among NUM_REQ one-shot delay requesters, round-robin.
// Optional watchdog: define FLEXCOUNTER_SCHED_WATCHDOG_EN to abort a RUN that never sees ctr_strobe.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | counter held clear, searching for the next requester
// ST_CLEAR | owner latched, counter cleared one cycle with maxCount valid
// ST_RUN   | counter enabled, waiting for strobe (or abort/watchdog)
// ST_DONE  | done pulse to owner, pointer moves to owner on exit
module flexcounter_scheduler #(
   parameter int NUM_REQ    = 4,
   parameter int COUNTSIZE  = 1024,
   parameter int COUNTWIDTH = $clog2(COUNTSIZE)
) (
   input  logic                          clk,
   input  logic                          nRST,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*COUNTWIDTH-1:0] req_max,
   output logic [NUM_REQ-1:0]            grant,
   output logic [NUM_REQ-1:0]            done,
   output logic                          busy,
   output logic                          sched_error,
   output logic                          ctr_nRST,
   output logic                          ctr_enable,
   output logic [COUNTWIDTH-1:0]         ctr_maxCount,
   input  logic                          ctr_strobe,
   input  logic [COUNTWIDTH-1:0]         ctr_count
);

   localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [IDXW-1:0]         owner_q, owner_d;
   logic [IDXW-1:0]         last_q, last_d;
   logic [COUNTWIDTH-1:0]   max_q, max_d;
   logic                    zero_pend_q, zero_pend_d;
   logic [NUM_REQ-1:0]      grant_q, grant_d;
   logic [NUM_REQ-1:0]      done_q, done_d;
   logic                    busy_q, busy_d;
   logic                    err_q, err_d;
   logic                    nrst_q, nrst_d;
   logic                    en_q, en_d;

   logic                    sel_found;
   logic [IDXW-1:0]         sel_idx;
   logic [COUNTWIDTH-1:0]   sel_max;
   logic                    wd_trip;
   logic                    ctr_count_unused;

   // The counter's own count is not needed for sequencing; strobe is authoritative.
   assign ctr_count_unused = ^ctr_count;

   // Round-robin search starting just after the last served owner.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!sel_found && req[IDXW'((int'(last_q) + k) % NUM_REQ)]) begin
            sel_found = 1'b1;
            sel_idx   = IDXW'((int'(last_q) + k) % NUM_REQ);
         end
      end
   end

   assign sel_max = req_max[sel_idx*COUNTWIDTH +: COUNTWIDTH];

`ifdef FLEXCOUNTER_SCHED_WATCHDOG_EN
   localparam int WDW = COUNTWIDTH + 2;

   logic [WDW-1:0] wd_q, wd_d, wd_inc;

   assign wd_inc  = wd_q + WDW'(1);
   // Trips once the RUN cycle count would pass max+2 without a strobe.
   assign wd_trip = (wd_inc > ({2'b00, max_q} + WDW'(2)));
`else
   assign wd_trip = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      max_d       = max_q;
      zero_pend_d = 1'b0;
      grant_d     = grant_q;
      done_d      = '0;
      err_d       = 1'b0;
      nrst_d      = nrst_q;
      en_d        = en_q;
`ifdef FLEXCOUNTER_SCHED_WATCHDOG_EN
      wd_d        = wd_q;
`endif
      case (state_q)
         ST_IDLE: begin
            grant_d = '0;
            nrst_d  = 1'b0;
            en_d    = 1'b0;
            if (sel_found) begin
               owner_d          = sel_idx;
               max_d            = sel_max;
               grant_d[sel_idx] = 1'b1;
               if (sel_max == '0) begin
                  // Zero delay skips the counter; DONE holds one extra cycle before pulsing.
                  state_d     = ST_DONE;
                  zero_pend_d = 1'b1;
               end else begin
                  state_d = ST_CLEAR;
               end
            end
         end
         ST_CLEAR: begin
            state_d = ST_RUN;
            nrst_d  = 1'b1;
            en_d    = 1'b1;
`ifdef FLEXCOUNTER_SCHED_WATCHDOG_EN
            wd_d    = '0;
`endif
         end
         ST_RUN: begin
            if (ctr_strobe) begin
               state_d         = ST_DONE;
               done_d[owner_q] = 1'b1;
               en_d            = 1'b0;
            end else if (wd_trip) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
               grant_d = '0;
               last_d  = owner_q;
               nrst_d  = 1'b0;
               en_d    = 1'b0;
            end else if (!req[owner_q]) begin
               state_d = ST_IDLE;
               grant_d = '0;
               nrst_d  = 1'b0;
               en_d    = 1'b0;
            end else begin
`ifdef FLEXCOUNTER_SCHED_WATCHDOG_EN
               wd_d = wd_inc;
`endif
            end
         end
         ST_DONE: begin
            if (zero_pend_q) begin
               done_d[owner_q] = 1'b1;
            end else begin
               state_d = ST_IDLE;
               grant_d = '0;
               last_d  = owner_q;
               nrst_d  = 1'b0;
               en_d    = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
            nrst_d  = 1'b0;
            en_d    = 1'b0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state_q     <= ST_IDLE;
         owner_q     <= '0;
         last_q      <= IDXW'(NUM_REQ - 1);
         max_q       <= '0;
         zero_pend_q <= 1'b0;
         grant_q     <= '0;
         done_q      <= '0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
         nrst_q      <= 1'b0;
         en_q        <= 1'b0;
`ifdef FLEXCOUNTER_SCHED_WATCHDOG_EN
         wd_q        <= '0;
`endif
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         max_q       <= max_d;
         zero_pend_q <= zero_pend_d;
         grant_q     <= grant_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
         nrst_q      <= nrst_d;
         en_q        <= en_d;
`ifdef FLEXCOUNTER_SCHED_WATCHDOG_EN
         wd_q        <= wd_d;
`endif
      end
   end

   assign grant        = grant_q;
   assign done         = done_q;
   assign busy         = busy_q;
   assign sched_error  = err_q;
   assign ctr_nRST     = nrst_q;
   assign ctr_enable   = en_q;
   assign ctr_maxCount = max_q;

endmodule
